// File: rtl/nem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nem_ctrl_pkg
//   Shared definitions for NEM-relay select controllers.
//   Contents:
//     nem_state_e   - controller state (IDLE, BREAK, MAKE, GRANT, PARK)
//     T_BREAK_MIN   - smallest legal break gap, in cycles
//     T_SETTLE_MIN  - smallest legal pull-in/settle time, in cycles
//     max_int()     - constant helper used when sizing timers
// ---------------------------------------------------------------------------
package nem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BREAK = 3'd1,
        MAKE  = 3'd2,
        GRANT = 3'd3,
        PARK  = 3'd4
    } nem_state_e;

    localparam int T_BREAK_MIN  = 1;
    localparam int T_SETTLE_MIN = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nem_rr_arb.sv
// ---------------------------------------------------------------------------
// nem_rr_arb
//   Combinational round-robin picker. Scans the request vector starting at
//   index 'start' and wrapping around; the first requester found wins.
//   Ports:
//     req     in   N       request vector
//     start   in   IDX_W   index searched first
//     onehot  out  N       one-hot winner (all zero when no request)
//     idx     out  IDX_W   binary winner index (zero when no request)
//     any     out  1       at least one request present
// ---------------------------------------------------------------------------
module nem_rr_arb
    import nem_ctrl_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    function automatic int wrap_idx(input int base, input int offset);
        return (base + offset) % N;
    endfunction

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[wrap_idx(int'(start), k)]) begin
                any                               = 1'b1;
                idx                               = IDX_W'(wrap_idx(int'(start), k));
                onehot[wrap_idx(int'(start), k)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// ---------------------------------------------------------------------------
// nem_ohmux_sel_ctrl
//   Select sequencer/arbiter for an N-input NEM-relay one-hot inverting mux.
//   Requesters are served round-robin; the select bus is driven
//   break-before-make with a settle delay before the grant, the relay stays
//   parked on its last owner, and relay pull-ins are counted for wear.
//   Ports:
//     CP       in   1       clock, rising edge
//     CDN      in   1       asynchronous active-low reset
//     REQ      in   N_IN    per-requester request, held for the whole use
//     S        out  N_IN    one-hot (or zero) relay select
//     GNT      out  N_IN    one-hot grant; zero or equal to S
//     BUSY     out  1       relay in motion (BREAK or MAKE)
//     ACT_CNT  out  CNT_W   saturating count of relay pull-ins
// ---------------------------------------------------------------------------
module nem_ohmux_sel_ctrl
    import nem_ctrl_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int T_BREAK  = 2,
    parameter int T_SETTLE = 4,
    parameter int CNT_W    = 16
) (
    input  logic              CP,
    input  logic              CDN,
    input  logic [N_IN-1:0]   REQ,
    output logic [N_IN-1:0]   S,
    output logic [N_IN-1:0]   GNT,
    output logic              BUSY,
    output logic [CNT_W-1:0]  ACT_CNT
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int TMR_W = $clog2(max_int(T_BREAK, T_SETTLE) + 1);

    localparam logic [TMR_W-1:0] BREAK_LOAD  = TMR_W'(T_BREAK - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(T_SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    if (N_IN < 2) begin : g_chk_n_in
        $error("nem_ohmux_sel_ctrl: N_IN must be at least 2");
    end
    if (T_BREAK < T_BREAK_MIN) begin : g_chk_t_break
        $error("nem_ohmux_sel_ctrl: T_BREAK below minimum");
    end
    if (T_SETTLE < T_SETTLE_MIN) begin : g_chk_t_settle
        $error("nem_ohmux_sel_ctrl: T_SETTLE below minimum");
    end
    if (CNT_W < 1) begin : g_chk_cnt_w
        $error("nem_ohmux_sel_ctrl: CNT_W must be at least 1");
    end

    nem_state_e        state, state_nx;
    logic [IDX_W-1:0]  owner, owner_nx;
    logic [IDX_W-1:0]  target, target_nx;
    logic [TMR_W-1:0]  tmr, tmr_nx;
    logic              act_inc;
    logic [IDX_W-1:0]  rr_start;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;
    logic [N_IN-1:0]   unused_win_onehot;
    logic [N_IN-1:0]   s_nx, gnt_nx;
    logic              busy_nx;

    // Round-robin search begins just past whoever the relay last served.
    // 'owner' tracks the relay position and is updated on MAKE entry, so
    // this also gives the right start point at the end of a MAKE.
    assign rr_start = (owner == IDX_W'(N_IN - 1)) ? '0 : owner + IDX_W'(1);

    nem_rr_arb #(
        .N     (N_IN),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (REQ),
        .start  (rr_start),
        .onehot (unused_win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // Next-state logic. One timer is shared by BREAK and MAKE; it is loaded
    // with duration-1 on entry and the phase ends when it reads zero.
    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        target_nx = target;
        tmr_nx    = tmr;
        act_inc   = 1'b0;
        case (state)
            IDLE: begin
                // Select bus is already open, so go straight to MAKE.
                if (win_any) begin
                    target_nx = win_idx;
                    owner_nx  = win_idx;
                    tmr_nx    = SETTLE_LOAD;
                    act_inc   = 1'b1;
                    state_nx  = MAKE;
                end
            end
            BREAK: begin
                if (tmr == '0) begin
                    owner_nx = target;
                    tmr_nx   = SETTLE_LOAD;
                    act_inc  = 1'b1;
                    state_nx = MAKE;
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            MAKE: begin
                // Requests are only re-examined once the relay has settled.
                if (tmr == '0) begin
                    if (REQ[target]) begin
                        state_nx = GRANT;
                    end else if (win_any) begin
                        target_nx = win_idx;
                        tmr_nx    = BREAK_LOAD;
                        state_nx  = BREAK;
                    end else begin
                        state_nx = PARK;
                    end
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            GRANT: begin
                if (!REQ[owner]) begin
                    if (win_any) begin
                        target_nx = win_idx;
                        tmr_nx    = BREAK_LOAD;
                        state_nx  = BREAK;
                    end else begin
                        state_nx = PARK;
                    end
                end
            end
            PARK: begin
                // The parked owner is served first: no relay motion needed.
                if (REQ[owner]) begin
                    state_nx = GRANT;
                end else if (win_any) begin
                    target_nx = win_idx;
                    tmr_nx    = BREAK_LOAD;
                    state_nx  = BREAK;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so
    // that S, GNT and BUSY can all be registered.
    always_comb begin
        s_nx    = '0;
        gnt_nx  = '0;
        busy_nx = (state_nx == BREAK) || (state_nx == MAKE);
        if (state_nx == MAKE || state_nx == GRANT || state_nx == PARK) begin
            s_nx[owner_nx] = 1'b1;
        end
        if (state_nx == GRANT) begin
            gnt_nx = s_nx;
        end
    end

    // State, bookkeeping and registered outputs. The async clear opens the
    // relay immediately.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state   <= IDLE;
            owner   <= '0;
            target  <= '0;
            tmr     <= '0;
            S       <= '0;
            GNT     <= '0;
            BUSY    <= 1'b0;
            ACT_CNT <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            target <= target_nx;
            tmr    <= tmr_nx;
            S      <= s_nx;
            GNT    <= gnt_nx;
            BUSY   <= busy_nx;
            if (act_inc && (ACT_CNT != CNT_MAX)) begin
                ACT_CNT <= ACT_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nem_ohmux_sel_ctrl
//   Two controllers share clock, reset and requests: one with default
//   parameters and one with a 4-bit actuation counter for saturation.
//   A timestamp-based relay model predicts all outputs every cycle.
// ---------------------------------------------------------------------------
module tb_nem_ohmux_sel_ctrl;

    localparam int N        = 4;
    localparam int T_BREAK  = 2;
    localparam int T_SETTLE = 4;

    logic          CP  = 1'b0;
    logic          CDN = 1'b1;
    logic [N-1:0]  REQ = '0;
    logic [N-1:0]  s, gnt, s_sat, gnt_sat;
    logic          busy, busy_sat;
    logic [15:0]   act_cnt;
    logic [3:0]    act_sat;

    int assert_count = 0;
    int fail_count   = 0;
    bit check_on     = 1'b0;

    // Relay model: drive is the selected input (-1 = relay open), goal the
    // input the relay is heading for, ready the cycle a motion completes.
    int     m_drive, m_home, m_goal, m_ready, m_t;
    bit     m_gnt, m_moving, m_opening;
    longint m_acts;

    nem_ohmux_sel_ctrl #(.N_IN(N), .T_BREAK(T_BREAK), .T_SETTLE(T_SETTLE), .CNT_W(16)) dut (
        .CP(CP), .CDN(CDN), .REQ(REQ), .S(s), .GNT(gnt), .BUSY(busy), .ACT_CNT(act_cnt)
    );

    nem_ohmux_sel_ctrl #(.N_IN(N), .T_BREAK(T_BREAK), .T_SETTLE(T_SETTLE), .CNT_W(4)) dut_sat (
        .CP(CP), .CDN(CDN), .REQ(REQ), .S(s_sat), .GNT(gnt_sat), .BUSY(busy_sat), .ACT_CNT(act_sat)
    );

    always #5 CP = ~CP;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic int oh_index(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_drive = -1; m_home = 0; m_goal = 0; m_ready = 0;
        m_gnt = 1'b0; m_moving = 1'b0; m_opening = 1'b0; m_acts = 0;
    endtask

    task automatic start_break(input int w);
        m_goal = w; m_drive = -1; m_moving = 1'b1; m_opening = 1'b1;
        m_ready = m_t + T_BREAK;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int w;
        m_t++;
        if (m_moving) begin
            if (m_t == m_ready) begin
                if (m_opening) begin
                    m_opening = 1'b0; m_drive = m_goal; m_home = m_goal;
                    m_acts++; m_ready = m_t + T_SETTLE;
                end else if (r[m_goal]) begin
                    m_moving = 1'b0; m_gnt = 1'b1;
                end else begin
                    w = pick(r, m_goal + 1);
                    if (w < 0) m_moving = 1'b0;
                    else start_break(w);
                end
            end
        end else if (m_drive < 0) begin
            w = pick(r, m_home + 1);
            if (w >= 0) begin
                m_drive = w; m_home = w; m_goal = w; m_acts++;
                m_moving = 1'b1; m_ready = m_t + T_SETTLE;
            end
        end else if (m_gnt) begin
            if (!r[m_drive]) begin
                m_gnt = 1'b0;
                w = pick(r, m_drive + 1);
                if (w >= 0) start_break(w);
            end
        end else begin
            if (r[m_drive]) m_gnt = 1'b1;
            else begin
                w = pick(r, m_drive + 1);
                if (w >= 0) start_break(w);
            end
        end
    endtask

    always @(posedge CP) begin
        if (CDN) model_step(REQ);
    end

    // Every cycle: both controllers against the model, plus the invariants.
    always @(negedge CP) begin
        if (check_on) begin
            logic [N-1:0] es, eg;
            es = (m_drive >= 0) ? N'(1 << m_drive) : '0;
            eg = m_gnt ? es : '0;
            checkOutput("s", 32'(s), 32'(es));
            checkOutput("gnt", 32'(gnt), 32'(eg));
            checkOutput("busy", 32'(busy), 32'(m_moving));
            checkOutput("act_cnt", 32'(act_cnt), (m_acts > 65535) ? 32'd65535 : 32'(m_acts));
            checkOutput("s_sat", 32'(s_sat), 32'(es));
            checkOutput("gnt_sat", 32'(gnt_sat), 32'(eg));
            checkOutput("act_sat", 32'(act_sat), (m_acts > 15) ? 32'd15 : 32'(m_acts));
            checkOutput("s_onehot0", 32'($onehot0(s)), 32'd1);
            checkOutput("gnt_vs_s", 32'((gnt == '0) || (gnt == s)), 32'd1);
        end
    end

    task automatic nextCycle();
        @(negedge CP);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input int cycles);
        REQ = r;
        repeat (cycles) nextCycle();
    endtask

    task automatic doReset();
        CDN = 1'b0;
        model_reset();
        REQ = '0;
        nextCycle();
        CDN = 1'b1;
    endtask

    task automatic waitGrant();
        int n = 0;
        while (gnt == '0 && n < 40) begin
            nextCycle();
            n++;
        end
        checkOutput("grant_wait", 32'(gnt != '0), 32'd1);
    endtask

    // Expected owner switch: two open cycles, four settle cycles, grant.
    task automatic checkSwitch(input logic [N-1:0] r, input logic [N-1:0] exp_oh);
        applyStimulus(r, 1);
        checkOutput("sw_gnt_drop", 32'(gnt), 32'd0);
        checkOutput("sw_break1", 32'(s), 32'd0);
        nextCycle();
        checkOutput("sw_break2", 32'(s), 32'd0);
        nextCycle();
        checkOutput("sw_make", 32'(s), 32'(exp_oh));
        repeat (3) nextCycle();
        checkOutput("sw_no_gnt", 32'(gnt), 32'd0);
        nextCycle();
        checkOutput("sw_gnt", 32'(gnt), 32'(exp_oh));
    endtask

    initial begin
        int order [6] = '{0, 1, 2, 3, 0, 1};
        int idx;
        model_reset();
        m_t = 0;
        #1 CDN = 1'b0;
        nextCycle();
        checkOutput("rst_s", 32'(s), 32'd0);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_act", 32'(act_cnt), 32'd0);
        CDN = 1'b1;
        check_on = 1'b1;

        $display("[TB] single request from idle");
        applyStimulus(4'b0001, 1);
        checkOutput("t1_s", 32'(s), 32'h1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_act", 32'(act_cnt), 32'd1);
        repeat (3) nextCycle();
        checkOutput("t1_gnt_wait", 32'(gnt), 32'd0);
        nextCycle();
        checkOutput("t1_gnt", 32'(gnt), 32'h1);
        checkOutput("t1_busy_low", 32'(busy), 32'd0);

        $display("[TB] owner switches");
        applyStimulus(4'b0111, 1);
        checkSwitch(4'b0110, 4'b0010);
        checkSwitch(4'b0100, 4'b0100);
        checkOutput("t2_act", 32'(act_cnt), 32'd3);

        $display("[TB] park and re-grant");
        doReset();
        applyStimulus(4'b0001, 5);
        checkOutput("t3_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0000, 1);
        checkOutput("t3_park_s", 32'(s), 32'h1);
        checkOutput("t3_park_gnt", 32'(gnt), 32'd0);
        applyStimulus(4'b0001, 1);
        checkOutput("t3_regrant", 32'(gnt), 32'h1);
        checkOutput("t3_act", 32'(act_cnt), 32'd1);

        $display("[TB] round-robin fairness");
        REQ = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            waitGrant();
            idx = oh_index(gnt);
            checkOutput("rr_order", 32'(idx), 32'(order[i]));
            repeat (2) nextCycle();
            if (idx >= 0) applyStimulus(4'b1111 & ~(4'b0001 << idx), 1);
            else nextCycle();
            REQ = 4'b1111;
        end

        $display("[TB] reset during settle");
        doReset();
        applyStimulus(4'b0010, 2);
        #2 CDN = 1'b0;
        model_reset();
        #1;
        checkOutput("t5_s", 32'(s), 32'd0);
        checkOutput("t5_gnt", 32'(gnt), 32'd0);
        checkOutput("t5_act", 32'(act_cnt), 32'd0);
        REQ = 4'b0100;
        nextCycle();
        CDN = 1'b1;
        nextCycle();
        checkOutput("t5_make", 32'(s), 32'h4);
        repeat (3) nextCycle();
        checkOutput("t5_no_gnt", 32'(gnt), 32'd0);
        nextCycle();
        checkOutput("t5_gnt", 32'(gnt), 32'h4);

        $display("[TB] counter saturation");
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b0001 : 4'b0010, 1);
            waitGrant();
        end
        checkOutput("t6_act_sat", 32'(act_sat), 32'd15);
        checkOutput("t6_act", 32'(act_cnt), 32'd21);

        $display("[TB] target dropped during settle");
        applyStimulus(4'b0100, 3);
        applyStimulus(4'b0000, 4);
        checkOutput("t6_park_s", 32'(s), 32'h4);
        checkOutput("t6_park_busy", 32'(busy), 32'd0);
        applyStimulus(4'b1000, 3);
        applyStimulus(4'b0001, 4);
        checkOutput("t6_rebreak_s", 32'(s), 32'd0);
        checkOutput("t6_rebreak_busy", 32'(busy), 32'd1);

        $display("[TB] random requests");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) REQ = 4'($urandom_range(15));
            else if ($urandom_range(3) == 0) REQ = REQ ^ (4'b0001 << $urandom_range(3));
            nextCycle();
        end

        check_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
